// File: rtl/sap_controller.sv
// sap_controller
//   Instruction register and microcode sequencer for the 8-bit bus computer.
//   A five-step T-counter (T0..T4) walks every instruction. T0/T1 fetch the
//   instruction into the IR. T2..T4 execute it, with the microcode selected
//   by the opcode nibble.
//   The control word is combinational. Bus agents sample it on the next
//   rising edge.
// Ports
//   clk     rising-edge clock
//   rst     asynchronous, active-low reset
//   en      step enable; low freezes the sequencer and zeroes ctrl
//   bus     shared bus, loaded into ir when II is asserted
//   carry   registered carry flag (conditional jump JC)
//   zero    registered zero flag (conditional jump JZ)
//   ctrl    16-bit control word:
//             HLT MI RI RO IO II AI AO EO SU BI OI CE CO J FI (bit 15..0)
//   ir      instruction register
//   tstate  current microstep, 0..4
//   halted  set by HLT; only rst clears it
module sap_controller #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] bus,
  input  logic             carry,
  input  logic             zero,
  output logic [15:0]      ctrl,
  output logic [WIDTH-1:0] ir,
  output logic [2:0]       tstate,
  output logic             halted
);

  localparam logic [15:0] C_HLT = 16'h8000;
  localparam logic [15:0] C_MI  = 16'h4000;
  localparam logic [15:0] C_RO  = 16'h1000;
  localparam logic [15:0] C_IO  = 16'h0800;
  localparam logic [15:0] C_II  = 16'h0400;
  localparam logic [15:0] C_AI  = 16'h0200;
  localparam logic [15:0] C_AO  = 16'h0100;
  localparam logic [15:0] C_EO  = 16'h0080;
  localparam logic [15:0] C_SU  = 16'h0040;
  localparam logic [15:0] C_BI  = 16'h0020;
  localparam logic [15:0] C_OI  = 16'h0010;
  localparam logic [15:0] C_CE  = 16'h0008;
  localparam logic [15:0] C_CO  = 16'h0004;
  localparam logic [15:0] C_J   = 16'h0002;
  localparam logic [15:0] C_FI  = 16'h0001;

  typedef enum logic [2:0] {T0 = 3'd0, T1 = 3'd1, T2 = 3'd2, T3 = 3'd3, T4 = 3'd4} tstep_t;

  tstep_t     state, state_nxt;
  logic       halted_nxt;
  logic [3:0] op;
  logic [15:0] micro;
  logic       run;

  assign op     = ir[WIDTH-1:WIDTH-4];
  assign tstate = state;
  // The sequencer only moves when enabled, not halted and out of reset.
  assign run    = rst && en && !halted;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= T0;
      halted <= 1'b0;
      ir     <= '0;
    end else begin
      state  <= state_nxt;
      halted <= halted_nxt;
      if (ctrl[10]) ir <= bus;
    end
  end

  always_comb begin
    micro      = '0;
    state_nxt  = state;
    halted_nxt = halted;

    unique case (state)
      T0: micro = C_CO | C_MI;
      T1: micro = C_RO | C_II | C_CE;
      T2: begin
        case (op)
          4'h1, 4'h2, 4'h3: micro = C_IO | C_MI;
          4'h5: micro = C_IO | C_AI;
          4'h6: micro = C_IO | C_J;
          // Flags are read live, so a flag change during T2 shows up at once.
          4'h7: micro = carry ? (C_IO | C_J) : 16'h0;
          4'h8: micro = zero  ? (C_IO | C_J) : 16'h0;
          4'hE: micro = C_AO | C_OI;
          4'hF: micro = C_HLT;
          default: micro = '0;
        endcase
      end
      T3: begin
        case (op)
          4'h1:       micro = C_RO | C_AI;
          4'h2, 4'h3: micro = C_RO | C_BI;
          default:    micro = '0;
        endcase
      end
      T4: begin
        case (op)
          4'h2:    micro = C_EO | C_AI | C_FI;
          4'h3:    micro = C_EO | C_AI | C_SU | C_FI;
          default: micro = '0;
        endcase
      end
      default: micro = '0;
    endcase

    ctrl = run ? micro : 16'h0;

    if (run) begin
      // HLT latches halted and parks the counter on T2.
      if (micro[15]) halted_nxt = 1'b1;
      else begin
        unique case (state)
          T0: state_nxt = T1;
          T1: state_nxt = T2;
          T2: state_nxt = T3;
          T3: state_nxt = T4;
          default: state_nxt = T0;
        endcase
      end
    end
  end

endmodule
